fetch_unit: RTL and testbench

Parametrised instruction-fetch front end that replaces the single-cycle PC register / PC-plus-4 / next-PC mux path of the datapath. It owns the PC and issues word-aligned requests to instruction memory over a valid/ready handshake, accepting in-order responses of any latency. Instructions go into a prefetch queue of configurable depth, and each one is presented to the decode stage together with its PC and PC+4. A redirect input from branch/jump resolution flushes the queue and discards stale in-flight responses.

---
 rtl/fetch_unit_pkg.sv | 28 ++
 rtl/fetch_unit_queue.sv | 119 +++++++++++
 rtl/fetch_unit.sv | 127 ++++++++++++
 tb/tb_fetch_unit.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// fetch_unit_pkg
// Shared constants and PC helper functions for the instruction-fetch front end.
// The helpers work on a wide PC (PC_MAX_W bits). Callers cast the result back
// to their own ADDR_W, so the carry out of the top bit is dropped and PC
// arithmetic wraps modulo 2^ADDR_W.
// ----------------------------------------------------------------------------
package fetch_unit_pkg;

    localparam int          PC_MAX_W         = 64;
    localparam int          INSTR_BYTES      = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef logic [PC_MAX_W-1:0] pc_max_t;

    function automatic pc_max_t add(input pc_max_t a, input pc_max_t b);
        return a + b;
    endfunction

    function automatic pc_max_t pc_increment(input pc_max_t pc);
        return add(pc, pc_max_t'(INSTR_BYTES));
    endfunction

    function automatic pc_max_t word_align(input pc_max_t addr);
        return {addr[PC_MAX_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// ----------------------------------------------------------------------------
// fetch_queue
// Prefetch queue. Each slot holds a fetch PC, the returned instruction and a
// filled flag.
// Three pointers walk the slots:
//   alloc - slot claimed when a request is issued
//   fill  - slot written by the next in-order response
//   read  - head slot presented to decode
// flush clears every slot and pointer, and it takes priority over a same-cycle
// alloc or fill. A same-cycle pop has already been consumed downstream.
// Ports:
//   clock, rst_n        clock and synchronous active-low reset
//   flush               drop every entry
//   alloc, alloc_pc     claim a slot for a request carrying alloc_pc
//   fill, fill_data     write the response into the fill slot
//   pop                 consume the head slot
//   head_valid/pc/data  head slot contents
//   occupancy           allocated slots, filled or pending
//   outstanding         allocated slots still waiting for data
// ----------------------------------------------------------------------------
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                         clock,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         alloc,
    input  logic [ADDR_W-1:0]            alloc_pc,
    input  logic                         fill,
    input  logic [DATA_W-1:0]            fill_data,
    input  logic                         pop,
    output logic                         head_valid,
    output logic [ADDR_W-1:0]            head_pc,
    output logic [DATA_W-1:0]            head_data,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [ADDR_W-1:0] pc_d   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [DEPTH-1:0]  filled_q, filled_d;
    logic [PTR_W-1:0]  alloc_ptr_q, alloc_ptr_d;
    logic [PTR_W-1:0]  fill_ptr_q, fill_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [OCC_W-1:0]  outst_q, outst_d;

    always_comb begin
        pc_d        = pc_q;
        data_d      = data_q;
        filled_d    = filled_q;
        alloc_ptr_d = alloc_ptr_q;
        fill_ptr_d  = fill_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q + OCC_W'(alloc) - OCC_W'(pop);
        outst_d     = outst_q + OCC_W'(alloc) - OCC_W'(fill);

        if (pop) begin
            filled_d[rd_ptr_q] = 1'b0;
            rd_ptr_d           = rd_ptr_q + PTR_W'(1);
        end
        if (alloc) begin
            pc_d[alloc_ptr_q] = alloc_pc;
            alloc_ptr_d       = alloc_ptr_q + PTR_W'(1);
        end
        if (fill) begin
            data_d[fill_ptr_q]   = fill_data;
            filled_d[fill_ptr_q] = 1'b1;
            fill_ptr_d           = fill_ptr_q + PTR_W'(1);
        end

        if (flush) begin
            filled_d    = '0;
            alloc_ptr_d = '0;
            fill_ptr_d  = '0;
            rd_ptr_d    = '0;
            occ_d       = '0;
            outst_d     = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            pc_q        <= '{default: '0};
            data_q      <= '{default: '0};
            filled_q    <= '0;
            alloc_ptr_q <= '0;
            fill_ptr_q  <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            outst_q     <= '0;
        end else begin
            pc_q        <= pc_d;
            data_q      <= data_d;
            filled_q    <= filled_d;
            alloc_ptr_q <= alloc_ptr_d;
            fill_ptr_q  <= fill_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            outst_q     <= outst_d;
        end
    end

    assign head_valid  = filled_q[rd_ptr_q];
    assign head_pc     = pc_q[rd_ptr_q];
    assign head_data   = data_q[rd_ptr_q];
    assign occupancy   = occ_q;
    assign outstanding = outst_q;

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction-fetch front end. It owns the PC and issues word-aligned requests
// over a valid/ready handshake. Requests are limited by a credit window that
// counts queue slots plus responses still owed for requests made before a
// redirect. In-order responses go into fetch_queue, which presents the head
// instruction with its PC and PC+4.
// Ports:
//   clock, reset                     clock, synchronous active-low reset
//   imem_req_valid/ready/addr        fetch request channel
//   imem_rsp_valid/data              in-order response channel
//   redirect_valid/addr              restart fetch at a new PC
//   inst_valid/ready/data/pc/pc_plus4  decode channel
//   occupancy                        allocated queue entries
// ----------------------------------------------------------------------------
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic                         clock,
    input  logic                         reset,
    output logic                         imem_req_valid,
    input  logic                         imem_req_ready,
    output logic [ADDR_W-1:0]            imem_req_addr,
    input  logic                         imem_rsp_valid,
    input  logic [DATA_W-1:0]            imem_rsp_data,
    input  logic                         redirect_valid,
    input  logic [ADDR_W-1:0]            redirect_addr,
    output logic                         inst_valid,
    input  logic                         inst_ready,
    output logic [DATA_W-1:0]            inst_data,
    output logic [ADDR_W-1:0]            inst_pc,
    output logic [ADDR_W-1:0]            inst_pc_plus4,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int               OCC_W   = $clog2(DEPTH+1);
    localparam logic [OCC_W:0]   DEPTH_C = (OCC_W+1)'(DEPTH);

    logic              reset_n_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [OCC_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic              head_valid;
    logic [ADDR_W-1:0] head_pc;
    logic [DATA_W-1:0] head_data;
    logic [OCC_W-1:0]  q_occ;
    logic [OCC_W-1:0]  q_outstanding;
    logic [OCC_W:0]    credit_used;
    logic              req_fire;
    logic              rsp_live;
    logic              rsp_dead;
    logic              out_fire;

    assign credit_used    = {1'b0, q_occ} + {1'b0, drop_cnt_q};
    assign imem_req_valid = reset_n_q && (credit_used < DEPTH_C);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign rsp_live       = imem_rsp_valid && (drop_cnt_q == '0);
    assign rsp_dead       = imem_rsp_valid && (drop_cnt_q != '0);
    assign out_fire       = head_valid && inst_ready;

    always_comb begin
        pc_d       = pc_q;
        drop_cnt_d = drop_cnt_q;
        if (redirect_valid) begin
            pc_d = ADDR_W'(word_align(PC_MAX_W'(redirect_addr)));
            // Every response still owed by memory becomes stale. This counts
            // the stale responses already pending, the unfilled queue slots
            // and a request firing this cycle, less the response arriving
            // now, which is discarded.
            drop_cnt_d = drop_cnt_q + q_outstanding + OCC_W'(req_fire)
                       - OCC_W'(rsp_live) - OCC_W'(rsp_dead);
        end else begin
            if (req_fire) begin
                pc_d = ADDR_W'(pc_increment(PC_MAX_W'(pc_q)));
            end
            if (rsp_dead) begin
                drop_cnt_d = drop_cnt_q - OCC_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            reset_n_q  <= 1'b0;
            pc_q       <= RESET_PC;
            drop_cnt_q <= '0;
        end else begin
            reset_n_q  <= 1'b1;
            pc_q       <= pc_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    fetch_queue #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_queue (
        .clock       (clock),
        .rst_n       (reset),
        .flush       (redirect_valid),
        .alloc       (req_fire && !redirect_valid),
        .alloc_pc    (pc_q),
        .fill        (rsp_live && !redirect_valid),
        .fill_data   (imem_rsp_data),
        .pop         (out_fire),
        .head_valid  (head_valid),
        .head_pc     (head_pc),
        .head_data   (head_data),
        .occupancy   (q_occ),
        .outstanding (q_outstanding)
    );

    // Head fields read as zero whenever nothing valid is presented.
    assign inst_valid    = head_valid;
    assign inst_data     = head_valid ? head_data : '0;
    assign inst_pc       = head_valid ? head_pc : '0;
    assign inst_pc_plus4 = head_valid ? ADDR_W'(pc_increment(PC_MAX_W'(head_pc))) : '0;
    assign occupancy     = q_occ;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clock;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc_plus4;
    logic [2:0]  occupancy;

    fetch_unit #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_pc_plus4  (inst_pc_plus4),
        .occupancy      (occupancy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: a memory holding in-flight requests tagged with the
    // fetch epoch that issued them, and the live instruction stream of the
    // current epoch in program order.
    bit          active = 1'b0;
    int          epoch  = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] mem_addr[$];
    int          mem_epoch[$];
    int          mem_due[$];
    int          last_due = 0;
    logic [31:0] live_pc[$];
    bit          live_filled[$];
    logic [31:0] live_data[$];
    int          lat_min = 1;
    int          lat_max = 1;
    int          n_req_fired = 0;
    int          n_delivered = 0;
    logic [31:0] del_pc_log[$];
    logic [31:0] del_p4_log[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hDEAD_BEEF;
    endfunction

    function automatic int stale_count();
        int n = 0;
        foreach (mem_epoch[i]) if (mem_epoch[i] != epoch) n++;
        return n;
    endfunction

    function automatic bit exp_req_valid();
        return active && ((live_pc.size() + stale_count()) < DEPTH);
    endfunction

    function automatic bit exp_inst_valid();
        return (live_pc.size() > 0) && live_filled[0];
    endfunction

    function automatic bit rsp_due_now();
        return (mem_addr.size() > 0) && (mem_due[0] <= cyc);
    endfunction

    task automatic run_cycle(input bit redir, input logic [31:0] raddr,
                             input bit irdy, input bit mrdy);
        bit          erv, eiv, rsp, rf, of;
        logic [31:0] rsp_a;
        int          r_ep, lat, due;
        @(negedge clock);
        imem_req_ready = mrdy;
        inst_ready     = irdy;
        redirect_valid = redir;
        redirect_addr  = raddr;
        rsp            = rsp_due_now();
        imem_rsp_valid = rsp;
        imem_rsp_data  = rsp ? mem_word(mem_addr[0]) : 32'h0;
        #1;
        erv = exp_req_valid();
        eiv = exp_inst_valid();

        n_checks++;
        if (imem_req_valid !== erv)
            $display("FAIL req_valid cyc=%0d got %b exp %b", cyc, imem_req_valid, erv);
        else n_pass++;
        n_checks++;
        if (imem_req_addr !== exp_pc)
            $display("FAIL req_addr cyc=%0d got %h exp %h", cyc, imem_req_addr, exp_pc);
        else n_pass++;
        n_checks++;
        if (occupancy !== 3'(live_pc.size()))
            $display("FAIL occupancy cyc=%0d got %0d exp %0d", cyc, occupancy, live_pc.size());
        else n_pass++;
        n_checks++;
        if (inst_valid !== eiv)
            $display("FAIL inst_valid cyc=%0d got %b exp %b", cyc, inst_valid, eiv);
        else n_pass++;
        if (eiv) begin
            n_checks++;
            if (inst_pc !== live_pc[0])
                $display("FAIL inst_pc cyc=%0d got %h exp %h", cyc, inst_pc, live_pc[0]);
            else n_pass++;
            n_checks++;
            if (inst_data !== live_data[0])
                $display("FAIL inst_data cyc=%0d got %h exp %h", cyc, inst_data, live_data[0]);
            else n_pass++;
            n_checks++;
            if (inst_pc_plus4 !== live_pc[0] + 32'd4)
                $display("FAIL inst_pc_plus4 cyc=%0d got %h exp %h", cyc, inst_pc_plus4, live_pc[0] + 32'd4);
            else n_pass++;
        end else begin
            n_checks++;
            if ({inst_pc, inst_data, inst_pc_plus4} !== 96'h0)
                $display("FAIL idle_fields cyc=%0d got %h/%h/%h exp 0", cyc, inst_pc, inst_data, inst_pc_plus4);
            else n_pass++;
        end

        rf = erv && mrdy;
        of = eiv && irdy;
        if (of) begin
            del_pc_log.push_back(live_pc[0]);
            del_p4_log.push_back(inst_pc_plus4);
            void'(live_pc.pop_front());
            void'(live_filled.pop_front());
            void'(live_data.pop_front());
            n_delivered++;
        end
        if (rsp) begin
            rsp_a = mem_addr.pop_front();
            r_ep  = mem_epoch.pop_front();
            void'(mem_due.pop_front());
            if (r_ep == epoch && !redir) begin
                for (int i = 0; i < live_filled.size(); i++) begin
                    if (!live_filled[i]) begin
                        live_filled[i] = 1'b1;
                        live_data[i]   = mem_word(rsp_a);
                        break;
                    end
                end
            end
        end
        if (rf) begin
            lat = $urandom_range(lat_max, lat_min);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_addr.push_back(exp_pc);
            mem_epoch.push_back(epoch);
            mem_due.push_back(due);
            if (!redir) begin
                live_pc.push_back(exp_pc);
                live_filled.push_back(1'b0);
                live_data.push_back(32'h0);
            end
            exp_pc = exp_pc + 32'd4;
            n_req_fired++;
        end
        if (redir) begin
            epoch++;
            live_pc.delete();
            live_filled.delete();
            live_data.delete();
            exp_pc = {raddr[31:2], 2'b00};
        end
        cyc++;
    endtask

    task automatic apply_reset(input int n);
        @(negedge clock);
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        inst_ready     = 1'b0;
        repeat (n) @(posedge clock);
        active = 1'b0;
        live_pc.delete();
        live_filled.delete();
        live_data.delete();
        mem_addr.delete();
        mem_epoch.delete();
        mem_due.delete();
        last_due = 0;
        exp_pc   = 32'h0;
        cyc += n;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        active = 1'b1;
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        apply_reset(2);
        n_checks++;
        if (imem_req_valid !== 1'b0 || inst_valid !== 1'b0)
            $display("FAIL reset_valids got req=%b inst=%b exp 0/0", imem_req_valid, inst_valid);
        else n_pass++;
        n_checks++;
        if (occupancy !== 3'd0 || imem_req_addr !== 32'h0)
            $display("FAIL reset_state got occ=%0d addr=%h exp 0/0", occupancy, imem_req_addr);
        else n_pass++;
        n_checks++;
        if ({inst_pc, inst_data, inst_pc_plus4} !== 96'h0)
            $display("FAIL reset_fields got %h/%h/%h exp 0", inst_pc, inst_data, inst_pc_plus4);
        else n_pass++;
        release_reset();
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0)
            $display("FAIL first_req got valid=%b addr=%h exp 1/00000000", imem_req_valid, imem_req_addr);
        else n_pass++;
    endtask

    task automatic test_sequential();
        int d0;
        lat_min = 1; lat_max = 1;
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        d0 = n_delivered;
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        n_checks++;
        if (n_delivered - d0 !== 10)
            $display("FAIL throughput got %0d exp 10 deliveries", n_delivered - d0);
        else n_pass++;
        n_checks++;
        if (del_pc_log[0] !== 32'h0 || del_pc_log[1] !== 32'h4 || del_pc_log[2] !== 32'h8)
            $display("FAIL seq_pcs got %h %h %h exp 0 4 8", del_pc_log[0], del_pc_log[1], del_pc_log[2]);
        else n_pass++;
    endtask

    task automatic test_full();
        int r0;
        lat_min = 1; lat_max = 1;
        run_cycle(1'b1, 32'h0000_0200, 1'b0, 1'b0);
        r0 = n_req_fired;
        for (int i = 0; i < 15; i++) run_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (n_req_fired - r0 !== 4)
            $display("FAIL full_reqs got %0d exp 4", n_req_fired - r0);
        else n_pass++;
        n_checks++;
        if (occupancy !== 3'd4 || imem_req_valid !== 1'b0)
            $display("FAIL full_state got occ=%0d valid=%b exp 4/0", occupancy, imem_req_valid);
        else n_pass++;
        run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        @(posedge clock); #1;
        n_checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0210)
            $display("FAIL credit_return got valid=%b addr=%h exp 1/00000210", imem_req_valid, imem_req_addr);
        else n_pass++;
        for (int i = 0; i < 5; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic test_redirect();
        int d0;
        lat_min = 5; lat_max = 5;
        run_cycle(1'b1, 32'h0000_0400, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        d0 = del_pc_log.size();
        run_cycle(1'b1, 32'h0000_1003, 1'b1, 1'b0);
        @(posedge clock); #1;
        n_checks++;
        if (imem_req_addr !== 32'h0000_1000 || inst_valid !== 1'b0)
            $display("FAIL redirect_addr got addr=%h inst_valid=%b exp 00001000/0", imem_req_addr, inst_valid);
        else n_pass++;
        for (int i = 0; i < 25; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        n_checks++;
        if (del_pc_log.size() <= d0)
            $display("FAIL redirect_first_pc got no delivery exp 00001000");
        else if (del_pc_log[d0] !== 32'h0000_1000)
            $display("FAIL redirect_first_pc got %h exp 00001000", del_pc_log[d0]);
        else n_pass++;
    endtask

    task automatic test_same_cycle();
        bit          found = 1'b0;
        logic [31:0] head;
        lat_min = 2; lat_max = 3;
        for (int i = 0; i < 300 && !found; i++) begin
            if (exp_inst_valid() && rsp_due_now() && mem_epoch[0] == epoch) begin
                head = live_pc[0];
                run_cycle(1'b1, 32'h0000_2000, 1'b1, 1'($urandom_range(1, 0)));
                n_checks++;
                if (inst_valid !== 1'b1 || inst_pc !== head || imem_rsp_valid !== 1'b1)
                    $display("FAIL same_cycle_deliver got valid=%b pc=%h exp 1/%h", inst_valid, inst_pc, head);
                else n_pass++;
                @(posedge clock); #1;
                n_checks++;
                if (occupancy !== 3'd0 || inst_valid !== 1'b0 || imem_req_addr !== 32'h0000_2000)
                    $display("FAIL same_cycle_flush got occ=%0d valid=%b addr=%h exp 0/0/00002000", occupancy, inst_valid, imem_req_addr);
                else n_pass++;
                found = 1'b1;
            end else begin
                run_cycle(1'b0, 32'h0, 1'($urandom_range(1, 0)), 1'b1);
            end
        end
        n_checks++;
        if (!found) $display("FAIL same_cycle_search got none exp scenario within 300 cycles");
        else n_pass++;
        for (int i = 0; i < 20; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic test_wrap();
        int d0;
        bit seen = 1'b0;
        lat_min = 1; lat_max = 1;
        d0 = del_pc_log.size();
        run_cycle(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0);
        for (int i = 0; i < 15; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
        for (int i = d0; i + 1 < del_pc_log.size(); i++) begin
            if (del_pc_log[i] == 32'hFFFF_FFFC && !seen) begin
                seen = 1'b1;
                n_checks++;
                if (del_p4_log[i] !== 32'h0 || del_pc_log[i+1] !== 32'h0)
                    $display("FAIL pc_wrap got p4=%h next=%h exp 00000000/00000000", del_p4_log[i], del_pc_log[i+1]);
                else n_pass++;
            end
        end
        n_checks++;
        if (!seen) $display("FAIL wrap_seen got none exp delivery at fffffffc");
        else n_pass++;
    endtask

    task automatic test_random();
        bit          rd;
        logic [31:0] ra;
        lat_min = 1; lat_max = 6;
        for (int i = 0; i < 1500; i++) begin
            rd = ($urandom_range(99, 0) < 3);
            ra = $urandom;
            run_cycle(rd, ra, ($urandom_range(99, 0) < 60), ($urandom_range(99, 0) < 70));
        end
    endtask

    task automatic test_reset_mid();
        lat_min = 1; lat_max = 2;
        for (int i = 0; i < 25; i++) run_cycle(1'b0, 32'h0, 1'b0, 1'b1);
        n_checks++;
        if (occupancy !== 3'd4)
            $display("FAIL mid_full got occ=%0d exp 4", occupancy);
        else n_pass++;
        apply_reset(1);
        n_checks++;
        if (inst_valid !== 1'b0 || occupancy !== 3'd0 || imem_req_addr !== 32'h0 || imem_req_valid !== 1'b0)
            $display("FAIL mid_reset got valid=%b occ=%0d addr=%h req=%b exp 0/0/0/0", inst_valid, occupancy, imem_req_addr, imem_req_valid);
        else n_pass++;
        release_reset();
        for (int i = 0; i < 12; i++) run_cycle(1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    initial begin
        reset          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0;
        inst_ready     = 1'b0;
        test_reset();
        test_sequential();
        test_full();
        test_redirect();
        test_same_cycle();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got no finish exp completion by 500000");
        $fatal(1, "timeout");
    end

endmodule
